// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: CPU run/step/halt controller for a single-cycle core.
//   Holds the core in reset until PLL lock has been stable for RST_HOLD_CYC cycles,
//   debounces the RUN switch and STEP button, produces a per-cycle clock enable
//   (free-run, single-step or halt) and counts executed cycles.
// Ports:
//   clk         in   CPU clock from the clock generator
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL lock flag (asynchronous to clk)
//   sw_run      in   raw RUN switch, 1 = run (asynchronous, bouncy)
//   btn_step    in   raw STEP button, 1 = pressed (asynchronous, bouncy)
//   cpu_rst_n   out  registered active-low reset to the core
//   cpu_en      out  registered clock enable to the core
//   state_o     out  FSM state: 0 HOLD, 1 HALT, 2 RUN, 3 STEP
//   cyc_cnt     out  number of cycles with cpu_en=1 (wraps)
module cpu_run_ctrl #(
    parameter int unsigned DEB_CYCLES   = 1000000,
    parameter int unsigned RST_HOLD_CYC = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sw_run,
    input  logic             btn_step,
    output logic             cpu_rst_n,
    output logic             cpu_en,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam int unsigned HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
    localparam int unsigned N_SYNC = 3;
    localparam int unsigned N_DEB  = 2;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_HALT = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } state_e;

    // Synchronizer bit order: 0 lock, 1 run, 2 step
    logic [N_SYNC-1:0] sync1_q;
    logic [N_SYNC-1:0] sync2_q;
    logic              lock_s;

    // Debounce slot order: 0 run, 1 step
    logic [N_DEB-1:0]  db_q;
    logic [N_DEB-1:0]  db_d;
    logic [DEB_W-1:0]  db_cnt_q [N_DEB];
    logic [DEB_W-1:0]  db_cnt_d [N_DEB];
    logic              step_prev_q;
    logic              step_pulse_c;
    logic              run_db;

    state_e            state_q;
    state_e            state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              cpu_en_q;
    logic              cpu_en_d;
    logic              cpu_rst_n_q;
    logic              cpu_rst_n_d;
    logic [CNT_W-1:0]  cyc_cnt_q;
    logic [CNT_W-1:0]  cyc_cnt_d;

    // Two-flop synchronizers for the asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_step, sw_run, pll_locked};
            sync2_q <= sync1_q;
        end
    end

    assign lock_s = sync2_q[0];

    // Debounce: the level only follows the synced input after it has differed
    // for DEB_CYCLES consecutive cycles; any return to equality restarts the count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < int'(N_DEB); i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i+1] != db_q[i]) begin
                if (db_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i+1];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q        <= '0;
            step_prev_q <= 1'b0;
            for (int i = 0; i < int'(N_DEB); i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q        <= db_d;
            step_prev_q <= db_q[1];
            for (int i = 0; i < int'(N_DEB); i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign run_db       = db_q[0];
    assign step_pulse_c = db_q[1] & ~step_prev_q;

    // Next-state logic; lock loss overrides everything, then run, then step
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        if (!lock_s) begin
            state_d = ST_HOLD;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_W'(RST_HOLD_CYC - 1)) begin
                        state_d = ST_HALT;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_HALT: begin
                    if (run_db) begin
                        state_d = ST_RUN;
                    end else if (step_pulse_c) begin
                        state_d = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (!run_db) begin
                        state_d = ST_HALT;
                    end
                end
                ST_STEP: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    // The cycle counter clears on the edge that enters (or stays in) HOLD.
    always_comb begin
        cpu_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
        cpu_rst_n_d = (state_d != ST_HOLD);
        cyc_cnt_d   = cyc_cnt_q;
        if (state_d == ST_HOLD) begin
            cyc_cnt_d = '0;
        end else if (cpu_en_q) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            cpu_en_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            cyc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

    assign state_o   = state_q;
    assign cpu_en    = cpu_en_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign cyc_cnt   = cyc_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed bench for cpu_run_ctrl with DEB_CYCLES=4,
// RST_HOLD_CYC=8, CNT_W=8. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point.
module tb_cpu_run_ctrl;

    localparam int unsigned DEB   = 4;
    localparam int unsigned HOLD  = 8;
    localparam int unsigned CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          sw_run;
    logic          btn_step;
    logic          cpu_rst_n;
    logic          cpu_en;
    logic [1:0]    state_o;
    logic [CW-1:0] cyc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_run_ctrl #(
        .DEB_CYCLES   (DEB),
        .RST_HOLD_CYC (HOLD),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .sw_run     (sw_run),
        .btn_step   (btn_step),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_en     (cpu_en),
        .state_o    (state_o),
        .cyc_cnt    (cyc_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        pll_locked = 1'b0;
        sw_run     = 1'b0;
        btn_step   = 1'b0;
        #2 rst_n   = 1'b0;
        tick(3);
        n_tests++;
        if ({state_o, cpu_rst_n, cpu_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_out state=%0d rst_n=%b en=%b exp 0/0/0", state_o, cpu_rst_n, cpu_en);
        end
        n_tests++;
        if (cyc_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got=%0d exp=0", cyc_cnt);
        end
        rst_n = 1'b1;
        tick(4);
        n_tests++;
        if (state_o !== 2'd0 || cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL nolock_hold state=%0d rst_n=%b exp 0/0", state_o, cpu_rst_n);
        end
    endtask

    task automatic test_lock_seq();
        pll_locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            n_tests++;
            if (cpu_rst_n !== (k == 10) || state_o !== ((k == 10) ? 2'd1 : 2'd0) || cpu_en !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_seq k=%0d rst_n=%b state=%0d en=%b exp rst_n=%b", k, cpu_rst_n, state_o, cpu_en, (k == 10));
            end
        end
    endtask

    task automatic test_bounce_run();
        for (int i = 0; i < 10; i++) begin
            sw_run = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                tick(1);
                n_tests++;
                if (state_o !== 2'd1) begin
                    n_fail++;
                    $display("FAIL bounce i=%0d state=%0d exp=1", i, state_o);
                end
            end
        end
        sw_run = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            n_tests++;
            if (state_o !== ((k == 7) ? 2'd2 : 2'd1) || cpu_en !== (k == 7)) begin
                n_fail++;
                $display("FAIL run_latency k=%0d state=%0d en=%b", k, state_o, cpu_en);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            n_tests++;
            if (cpu_en !== 1'b1 || cyc_cnt !== 8'(k)) begin
                n_fail++;
                $display("FAIL run_count k=%0d en=%b cnt=%0d exp=%0d", k, cpu_en, cyc_cnt, k);
            end
        end
        sw_run = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            n_tests++;
            if (state_o !== ((k == 7) ? 2'd1 : 2'd2)) begin
                n_fail++;
                $display("FAIL run_drop k=%0d state=%0d", k, state_o);
            end
        end
        n_tests++;
        if (cyc_cnt !== 8'd12 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL run_drop_cnt cnt=%0d en=%b exp 12/0", cyc_cnt, cpu_en);
        end
        tick(3);
        n_tests++;
        if (cyc_cnt !== 8'd12) begin
            n_fail++;
            $display("FAIL halt_freeze cnt=%0d exp=12", cyc_cnt);
        end
    endtask

    task automatic test_step();
        int en_cnt;
        int st3_cnt;
        en_cnt   = 0;
        st3_cnt  = 0;
        btn_step = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            if (cpu_en === 1'b1) en_cnt++;
            if (state_o === 2'd3) st3_cnt++;
            if (k == 7) begin
                n_tests++;
                if (state_o !== 2'd3) begin
                    n_fail++;
                    $display("FAIL step_enter state=%0d exp=3", state_o);
                end
            end
            if (k == 8) begin
                n_tests++;
                if (state_o !== 2'd1 || cyc_cnt !== 8'd13) begin
                    n_fail++;
                    $display("FAIL step_exit state=%0d cnt=%0d exp 1/13", state_o, cyc_cnt);
                end
            end
        end
        n_tests++;
        if (en_cnt != 1 || st3_cnt != 1) begin
            n_fail++;
            $display("FAIL step_once en_cycles=%0d step_cycles=%0d exp 1/1", en_cnt, st3_cnt);
        end
        btn_step = 1'b0;
        tick(10);
        n_tests++;
        if (cyc_cnt !== 8'd13 || state_o !== 2'd1) begin
            n_fail++;
            $display("FAIL step_release cnt=%0d state=%0d exp 13/1", cyc_cnt, state_o);
        end
    endtask

    task automatic test_wrap();
        sw_run = 1'b1;
        tick(7);
        n_tests++;
        if (state_o !== 2'd2 || cyc_cnt !== 8'd13) begin
            n_fail++;
            $display("FAIL wrap_start state=%0d cnt=%0d exp 2/13", state_o, cyc_cnt);
        end
        for (int k = 1; k <= 300; k++) begin
            tick(1);
            if (k == 242 || k == 243) begin
                n_tests++;
                if (cyc_cnt !== ((k == 242) ? 8'd255 : 8'd0)) begin
                    n_fail++;
                    $display("FAIL wrap k=%0d cnt=%0d", k, cyc_cnt);
                end
            end
        end
        n_tests++;
        if (cyc_cnt !== 8'd57) begin
            n_fail++;
            $display("FAIL wrap_end cnt=%0d exp=57", cyc_cnt);
        end
        sw_run = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            if (k >= 6) begin
                n_tests++;
                if (state_o !== ((k == 7) ? 2'd1 : 2'd2)) begin
                    n_fail++;
                    $display("FAIL wrap_drop k=%0d state=%0d", k, state_o);
                end
            end
        end
        tick(3);
        n_tests++;
        if (cyc_cnt !== 8'd64 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_freeze cnt=%0d en=%b exp 64/0", cyc_cnt, cpu_en);
        end
    endtask

    task automatic test_lock_loss();
        sw_run = 1'b1;
        tick(10);
        n_tests++;
        if (state_o !== 2'd2 || cyc_cnt !== 8'd67) begin
            n_fail++;
            $display("FAIL ll_run state=%0d cnt=%0d exp 2/67", state_o, cyc_cnt);
        end
        pll_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            if (k == 2) begin
                n_tests++;
                if (state_o !== 2'd2) begin
                    n_fail++;
                    $display("FAIL ll_sync state=%0d exp=2", state_o);
                end
            end
        end
        n_tests++;
        if ({state_o, cpu_rst_n, cpu_en} !== 4'b0000 || cyc_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL ll_hold state=%0d rst_n=%b en=%b cnt=%0d exp 0/0/0/0", state_o, cpu_rst_n, cpu_en, cyc_cnt);
        end
        tick(5);
        pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            if (k >= 9) begin
                n_tests++;
                if (state_o !== ((k == 9) ? 2'd0 : (k == 10) ? 2'd1 : 2'd2) ||
                    cpu_rst_n !== (k >= 10) || cpu_en !== (k == 11)) begin
                    n_fail++;
                    $display("FAIL ll_reseq k=%0d state=%0d rst_n=%b en=%b", k, state_o, cpu_rst_n, cpu_en);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        sw_run = 1'b0;
        tick(7);
        btn_step = 1'b1;
        tick(7);
        n_tests++;
        if (state_o !== 2'd3 || cpu_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_step state=%0d en=%b exp 3/1", state_o, cpu_en);
        end
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({state_o, cpu_rst_n, cpu_en} !== 4'b0000 || cyc_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL ar_clear state=%0d rst_n=%b en=%b cnt=%0d exp 0/0/0/0", state_o, cpu_rst_n, cpu_en, cyc_cnt);
        end
        tick(1);
        sw_run   = 1'b0;
        btn_step = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        n_tests++;
        if (state_o !== 2'd1 || cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_reseq state=%0d rst_n=%b exp 1/1", state_o, cpu_rst_n);
        end
        sw_run   = 1'b1;
        btn_step = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k >= 6) begin
                n_tests++;
                if (state_o !== ((k == 6) ? 2'd1 : 2'd2) || cpu_en !== (k >= 7)) begin
                    n_fail++;
                    $display("FAIL ar_prec k=%0d state=%0d en=%b", k, state_o, cpu_en);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_seq();
        test_bounce_run();
        test_step();
        test_wrap();
        test_lock_loss();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
